pc_fetch_controller: RTL and testbench
======================================

Name: pc_fetch_controller

Overview:
Sequences the IF stage of the RV32IM pipeline. It owns the PC register and selects the next PC each cycle: reset vector, PC+4, or a branch/jump redirect. It arbitrates between instruction-memory busywait, data-memory busywait, load-use stalls and redirects, and drives IF/ID write-enable and flush. It replaces the free-running PC/adder pairing with an explicit FSM.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
PC_STEP, 32'd4, sequential increment

Ports:
CLOCK  input  1  pipeline clock, all state updates on posedge
RESET  input  1  synchronous, active-high
IMEM_BUSYWAIT  input  1  instruction memory not ready; fetched word invalid this cycle
DMEM_BUSYWAIT  input  1  data memory stall; freezes whole pipeline
STALL_ID  input  1  load-use hazard from ID; hold PC and IF/ID
BRANCH_TAKEN  input  1  redirect request from EX (branch taken / JAL / JALR)
BRANCH_TARGET  input  32  redirect address
PC  output  32  current fetch address (registered)
IMEM_READ  output  1  fetch request to instruction memory (registered)
IFID_WRITE  output  1  IF/ID register capture enable (combinational)
FLUSH_IFID  output  1  IF/ID bubble insert (combinational)
WAIT_CYCLES  output  32  count of cycles spent in WAIT_IMEM (registered)

Behaviour:
- Reset is synchronous and active-high: RESET=1 at a posedge sets state=BOOT, PC=RESET_VECTOR, IMEM_READ=0, pending=0, WAIT_CYCLES=0. While RESET=1: IFID_WRITE=0, FLUSH_IFID=1. Reset mid-WAIT discards any pending redirect.
- States: BOOT, FETCH, WAIT_IMEM.
- BOOT: IFID_WRITE=0, FLUSH_IFID=1. Next edge goes to FETCH with IMEM_READ=1. The first fetch of RESET_VECTOR is issued the cycle after reset deasserts.
- FETCH, per cycle. Priority is highest first, one action per edge:
  1. DMEM_BUSYWAIT: hold PC and state; IFID_WRITE=0, FLUSH_IFID=0. Redirect inputs are not sampled; EX is frozen and holds them stable.
  2. BRANCH_TAKEN: PC<=BRANCH_TARGET with bits [1:0] forced to 00; FLUSH_IFID=1, IFID_WRITE=1 (bubble written). Applies even if IMEM_BUSYWAIT=1 in the same cycle, because the in-flight fetch is discarded; stay in FETCH.
  3. IMEM_BUSYWAIT: hold PC; IFID_WRITE=0; go to WAIT_IMEM.
  4. STALL_ID: hold PC; IFID_WRITE=0, FLUSH_IFID=0.
  5. Otherwise: PC<=PC+PC_STEP (modulo 2^32; 32'hFFFF_FFFC wraps to 0); IFID_WRITE=1.
- WAIT_IMEM: IMEM_READ stays 1, PC held, IFID_WRITE=0, WAIT_CYCLES increments each cycle (saturates at all-ones).
  - BRANCH_TAKEN (when DMEM_BUSYWAIT=0) latches the aligned target into pending_target and sets pending=1. A later redirect overwrites it, so the newest redirect wins.
  - When IMEM_BUSYWAIT falls and pending=1: PC<=pending_target, FLUSH_IFID=1, IFID_WRITE=1, pending<=0, go to FETCH.
  - When IMEM_BUSYWAIT falls, pending=0 and BRANCH_TAKEN=1 that cycle: treat as FETCH priority 2.
  - Otherwise, when IMEM_BUSYWAIT falls: apply FETCH priorities 4/5, go to FETCH.
  - DMEM_BUSYWAIT high in WAIT_IMEM blocks the exit; the state is held until both busywaits are low.
- IMEM_READ is never deasserted after BOOT except by RESET.
- FLUSH_IFID and IFID_WRITE are never both derived from stale state. They are decoded from the current state and inputs in the same cycle as the edge they qualify.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding: BOOT=2'b00, FETCH=2'b01, WAIT_IMEM=2'b10
  - RESET_VECTOR default
  - PC_STEP
- One natural sub-module, pc_redirect_buffer: pending flag plus pending_target, with set/overwrite/clear on synchronous reset.
- The existing +4 adder may be reused for PC+PC_STEP.

Test Plan:
- Reset: RESET=1 for 2 cycles then 0 -> PC=0, IMEM_READ=0 in BOOT; next cycle IMEM_READ=1; subsequent edges PC=0,4,8,C with IFID_WRITE=1.
- IMEM busywait: IMEM_BUSYWAIT=1 for 3 cycles at PC=0x10 -> PC held 0x10, IFID_WRITE=0, WAIT_CYCLES=3; on release PC=0x14.
- Redirect during wait: IMEM_BUSYWAIT=1 at PC=0x20, BRANCH_TAKEN pulse with target 0x103 in cycle 2 -> PC stays 0x20; on release PC=0x100, FLUSH_IFID=1 for exactly one cycle.
- Priority: DMEM_BUSYWAIT=1 with BRANCH_TAKEN=1 (target 0x200) and STALL_ID=1 -> PC unchanged. DMEM drops with BRANCH_TAKEN still 1 -> PC=0x200, flush asserted.
- Load-use: STALL_ID=1 one cycle at PC=0x40 -> PC held 0x40, IFID_WRITE=0, FLUSH_IFID=0; next PC=0x44.
- Wrap/reset mid-op: PC=0xFFFF_FFFC advances to 0. RESET during WAIT_IMEM with pending=1 -> PC=RESET_VECTOR, pending redirect lost, WAIT_CYCLES=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the IF-stage fetch controller
package fetch_pkg;

    // FSM encoding is fixed so waveforms and downstream debug tools agree on values
    typedef enum logic [1:0] {
        ST_BOOT      = 2'b00,
        ST_FETCH     = 2'b01,
        ST_WAIT_IMEM = 2'b10
    } fetch_state_e;

    // What happens to the PC register on the coming edge
    typedef enum logic [1:0] {
        ACT_HOLD     = 2'b00,
        ACT_STEP     = 2'b01,
        ACT_REDIRECT = 2'b10,
        ACT_PENDING  = 2'b11
    } pc_action_e;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_STEP      = 32'd4;

    // Instruction fetches are word aligned; low address bits of a redirect are dropped
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - holds one redirect that arrived while a fetch was stalled
module pc_redirect_buffer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        set_i,
    input  logic        clear_i,
    input  logic [31:0] target_i,
    output logic        pending_o,
    output logic [31:0] target_o
);

    logic        pending_q;
    logic [31:0] target_q;

    // A new redirect always overwrites an older one, so the newest request wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            target_q  <= '0;
        end else if (set_i) begin
            pending_q <= 1'b1;
            target_q  <= target_i;
        end else if (clear_i) begin
            pending_q <= 1'b0;
        end
    end

    assign pending_o = pending_q;
    assign target_o  = target_q;

endmodule

// File: rtl/pc_fetch_controller.sv
// rtl/pc_fetch_controller.sv - IF-stage PC sequencer with stall, busywait and redirect arbitration
module pc_fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] PC_STEP      = DEFAULT_PC_STEP
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        IMEM_BUSYWAIT,
    input  logic        DMEM_BUSYWAIT,
    input  logic        STALL_ID,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC,
    output logic        IMEM_READ,
    output logic        IFID_WRITE,
    output logic        FLUSH_IFID,
    output logic [31:0] WAIT_CYCLES
);

    fetch_state_e state_q, state_d;
    pc_action_e   action;
    logic [31:0]  pc_q, pc_d;
    logic         imem_read_q;
    logic [31:0]  wait_cycles_q;
    logic         ifid_write;
    logic         flush_ifid;
    logic         buf_set;
    logic         buf_clear;
    logic         pending;
    logic [31:0]  pending_target;
    logic [31:0]  aligned_target;
    logic [31:0]  pc_plus_step;

    assign aligned_target = align_word(BRANCH_TARGET);
    assign pc_plus_step   = pc_q + PC_STEP;

    pc_redirect_buffer u_redirect_buffer (
        .clk_i     (CLOCK),
        .rst_i     (RESET),
        .set_i     (buf_set),
        .clear_i   (buf_clear),
        .target_i  (aligned_target),
        .pending_o (pending),
        .target_o  (pending_target)
    );

    // Decode this cycle's PC action and IF/ID controls from the current state and live inputs
    always_comb begin
        state_d    = state_q;
        action     = ACT_HOLD;
        ifid_write = 1'b0;
        flush_ifid = 1'b0;
        buf_set    = 1'b0;
        buf_clear  = 1'b0;
        if (RESET) begin
            flush_ifid = 1'b1;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    flush_ifid = 1'b1;
                    state_d    = ST_FETCH;
                end
                ST_FETCH: begin
                    if (DMEM_BUSYWAIT) begin
                        action = ACT_HOLD;
                    end else if (BRANCH_TAKEN) begin
                        // The in-flight fetch is wrong-path, so a busy IMEM is irrelevant here
                        action     = ACT_REDIRECT;
                        ifid_write = 1'b1;
                        flush_ifid = 1'b1;
                    end else if (IMEM_BUSYWAIT) begin
                        state_d = ST_WAIT_IMEM;
                    end else if (!STALL_ID) begin
                        action     = ACT_STEP;
                        ifid_write = 1'b1;
                    end
                end
                ST_WAIT_IMEM: begin
                    if (DMEM_BUSYWAIT) begin
                        action = ACT_HOLD;
                    end else if (IMEM_BUSYWAIT) begin
                        buf_set = BRANCH_TAKEN;
                    end else begin
                        state_d = ST_FETCH;
                        if (pending) begin
                            action     = ACT_PENDING;
                            ifid_write = 1'b1;
                            flush_ifid = 1'b1;
                            buf_clear  = 1'b1;
                        end else if (BRANCH_TAKEN) begin
                            action     = ACT_REDIRECT;
                            ifid_write = 1'b1;
                            flush_ifid = 1'b1;
                        end else if (!STALL_ID) begin
                            action     = ACT_STEP;
                            ifid_write = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // Select the next PC value from the decoded action
    always_comb begin
        pc_d = pc_q;
        case (action)
            ACT_STEP:     pc_d = pc_plus_step;
            ACT_REDIRECT: pc_d = aligned_target;
            ACT_PENDING:  pc_d = pending_target;
            default:      pc_d = pc_q;
        endcase
    end

    // Fetch FSM, PC register, fetch request and wait-cycle counter
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            imem_read_q   <= 1'b0;
            wait_cycles_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (state_q == ST_BOOT) begin
                imem_read_q <= 1'b1;
            end
            if (state_q == ST_WAIT_IMEM && wait_cycles_q != '1) begin
                wait_cycles_q <= wait_cycles_q + 32'd1;
            end
        end
    end

    assign PC          = pc_q;
    assign IMEM_READ   = imem_read_q;
    assign WAIT_CYCLES = wait_cycles_q;
    assign IFID_WRITE  = ifid_write;
    assign FLUSH_IFID  = flush_ifid;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// tb/tb_pc_fetch_controller.sv - self-checking bench for pc_fetch_controller
module tb_pc_fetch_controller;

    logic        CLOCK = 1'b0;
    logic        RESET, IMEM_BUSYWAIT, DMEM_BUSYWAIT, STALL_ID, BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] PC, WAIT_CYCLES;
    logic        IMEM_READ, IFID_WRITE, FLUSH_IFID;

    int tests = 0;
    int fails = 0;

    pc_fetch_controller #(.RESET_VECTOR(32'h0), .PC_STEP(32'd4)) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .DMEM_BUSYWAIT (DMEM_BUSYWAIT),
        .STALL_ID      (STALL_ID),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .PC            (PC),
        .IMEM_READ     (IMEM_READ),
        .IFID_WRITE    (IFID_WRITE),
        .FLUSH_IFID    (FLUSH_IFID),
        .WAIT_CYCLES   (WAIT_CYCLES)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        bit          rst, im, dm, st, br;
        logic [31:0] tgt;
        logic [31:0] pc;
        bit          rd;
        logic [31:0] wc;
        bit          wr, fl;
    } vec_t;

    vec_t tbl[$];

    // reference model: 0 = booting, 1 = running, 2 = waiting on instruction memory
    int          m_phase = 0;
    logic [31:0] m_pc = 32'h0;
    bit          m_rd = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_ptgt = 32'h0;
    longint      m_wc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void add(bit rst, bit im, bit dm, bit st, bit br, logic [31:0] tgt,
                                logic [31:0] pc, bit rd, logic [31:0] wc, bit wr, bit fl);
        vec_t v;
        v.rst = rst; v.im = im; v.dm = dm; v.st = st; v.br = br; v.tgt = tgt;
        v.pc = pc; v.rd = rd; v.wc = wc; v.wr = wr; v.fl = fl;
        tbl.push_back(v);
    endfunction

    task automatic drive(bit rst, bit im, bit dm, bit st, bit br, logic [31:0] tgt);
        RESET = rst; IMEM_BUSYWAIT = im; DMEM_BUSYWAIT = dm;
        STALL_ID = st; BRANCH_TAKEN = br; BRANCH_TARGET = tgt;
        #1;
    endtask

    // Expected IF/ID controls for the inputs currently applied
    function automatic void model_ctrl(output bit wr, output bit fl);
        bit waiting = (m_phase == 2);
        wr = 1'b0; fl = 1'b0;
        if (RESET || m_phase == 0) begin
            fl = 1'b1;
        end else if (DMEM_BUSYWAIT) begin
            wr = 1'b0;
        end else if (waiting && IMEM_BUSYWAIT) begin
            wr = 1'b0;
        end else if ((waiting && m_pend) || BRANCH_TAKEN) begin
            wr = 1'b1; fl = 1'b1;
        end else if (!waiting && IMEM_BUSYWAIT) begin
            wr = 1'b0;
        end else begin
            wr = !STALL_ID;
        end
    endfunction

    task automatic model_edge();
        bit waiting = (m_phase == 2);
        if (RESET) begin
            m_phase = 0; m_pc = 32'h0; m_rd = 1'b0; m_pend = 1'b0; m_wc = 0;
        end else begin
            if (waiting) m_wc = (m_wc + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_wc + 1;
            if (m_phase == 0) begin
                m_phase = 1; m_rd = 1'b1;
            end else if (DMEM_BUSYWAIT) begin
                // frozen
            end else if (waiting && IMEM_BUSYWAIT) begin
                if (BRANCH_TAKEN) begin
                    m_pend = 1'b1;
                    m_ptgt = BRANCH_TARGET & ~32'd3;
                end
            end else if (waiting && m_pend) begin
                m_pc = m_ptgt; m_pend = 1'b0; m_phase = 1;
            end else if (BRANCH_TAKEN) begin
                m_pc = BRANCH_TARGET & ~32'd3; m_phase = 1;
            end else if (IMEM_BUSYWAIT) begin
                m_phase = 2;
            end else begin
                if (!STALL_ID) m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                m_phase = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        model_edge();
        @(negedge CLOCK);
    endtask

    initial begin
        bit ewr, efl;
        //  rst im dm st br tgt             pc            rd wc  wr fl
        add(1, 0, 0, 0, 0, 32'h0,          32'h0,         0, 0, 0, 1);  // 0 reset held
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,         0, 0, 0, 1);  // 1 boot
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,         1, 0, 1, 0);  // 2
        add(0, 0, 0, 0, 0, 32'h0,          32'h4,         1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h8,         1, 0, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'hC,         1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h10,        1, 0, 0, 0);  // 6 imem busy
        add(0, 1, 0, 0, 0, 32'h0,          32'h10,        1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h10,        1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h10,        1, 2, 1, 0);  // 9 release
        add(0, 0, 0, 0, 0, 32'h0,          32'h14,        1, 3, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h18,        1, 3, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h1C,        1, 3, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h20,        1, 3, 0, 0);  // 13 redirect in wait
        add(0, 1, 0, 0, 1, 32'h103,        32'h20,        1, 3, 0, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h20,        1, 4, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h20,        1, 5, 1, 1);
        add(0, 0, 0, 0, 0, 32'h0,          32'h100,       1, 6, 1, 0);  // 17 flush gone
        add(0, 0, 1, 1, 1, 32'h200,        32'h104,       1, 6, 0, 0);  // 18 dmem priority
        add(0, 0, 1, 1, 1, 32'h200,        32'h104,       1, 6, 0, 0);
        add(0, 0, 0, 1, 1, 32'h200,        32'h104,       1, 6, 1, 1);
        add(0, 0, 0, 0, 0, 32'h0,          32'h200,       1, 6, 1, 0);
        add(0, 0, 0, 0, 1, 32'h41,         32'h204,       1, 6, 1, 1);  // 22 to 0x40
        add(0, 0, 0, 1, 0, 32'h0,          32'h40,        1, 6, 0, 0);  // 23 load-use
        add(0, 0, 0, 0, 0, 32'h0,          32'h40,        1, 6, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h44,        1, 6, 1, 0);
        add(0, 0, 0, 0, 1, 32'hFFFF_FFFF,  32'h48,        1, 6, 1, 1);  // 26 to top
        add(0, 0, 0, 0, 0, 32'h0,          32'hFFFF_FFFC, 1, 6, 1, 0);  // 27 wrap
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,         1, 6, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h4,         1, 6, 0, 0);  // 29 wait
        add(0, 1, 0, 0, 1, 32'h300,        32'h4,         1, 6, 0, 0);  // pending set
        add(1, 1, 0, 0, 0, 32'h0,          32'h4,         1, 7, 0, 1);  // 31 reset mid-wait
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,         0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 32'h0,          32'h0,         1, 0, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'h4,         1, 0, 0, 0);  // 34
        add(0, 0, 0, 0, 0, 32'h0,          32'h4,         1, 0, 1, 0);  // pending lost
        add(0, 0, 0, 0, 0, 32'h0,          32'h8,         1, 1, 1, 0);
        add(0, 1, 0, 0, 0, 32'h0,          32'hC,         1, 1, 0, 0);  // 37 dmem in wait
        add(0, 0, 1, 0, 0, 32'h0,          32'hC,         1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'hC,         1, 2, 1, 0);
        add(0, 0, 0, 0, 0, 32'h0,          32'h10,        1, 3, 1, 0);

        drive(1, 0, 0, 0, 0, 32'h0);
        step();

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].im, tbl[i].dm, tbl[i].st, tbl[i].br, tbl[i].tgt);
            chk($sformatf("vec%0d PC", i),          PC,          tbl[i].pc);
            chk($sformatf("vec%0d IMEM_READ", i),   32'(IMEM_READ),  32'(tbl[i].rd));
            chk($sformatf("vec%0d WAIT_CYCLES", i), WAIT_CYCLES, tbl[i].wc);
            chk($sformatf("vec%0d IFID_WRITE", i),  32'(IFID_WRITE), 32'(tbl[i].wr));
            chk($sformatf("vec%0d FLUSH_IFID", i),  32'(FLUSH_IFID), 32'(tbl[i].fl));
            step();
        end

        for (int n = 0; n < 800; n++) begin
            drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 5) == 0), $urandom);
            model_ctrl(ewr, efl);
            chk($sformatf("rnd%0d PC", n),          PC,          m_pc);
            chk($sformatf("rnd%0d IMEM_READ", n),   32'(IMEM_READ),  32'(m_rd));
            chk($sformatf("rnd%0d WAIT_CYCLES", n), WAIT_CYCLES, 32'(m_wc));
            chk($sformatf("rnd%0d IFID_WRITE", n),  32'(IFID_WRITE), 32'(ewr));
            chk($sformatf("rnd%0d FLUSH_IFID", n),  32'(FLUSH_IFID), 32'(efl));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
